// File: rtl/lcg_stim_sequencer.sv
// Stimulus sequencer: builds IN_W-bit words from a 32-bit LCG, one 32-bit chunk per
// cycle, and hands each finished word to a consumer over a valid/ready handshake.
module lcg_stim_sequencer #(
  parameter int          IN_W  = 139,
  parameter int          CNT_W = 32,
  parameter logic [31:0] LCG_A = 32'h41C64E6D,
  parameter logic [31:0] LCG_C = 32'h00003039
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] num_words,
  output logic [IN_W-1:0]  stim_data,
  output logic             stim_valid,
  input  logic             stim_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] word_count
);

  localparam int NCHUNK  = (IN_W + 31) / 32;
  localparam int CHUNK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t             state;
  logic [31:0]        rng;
  logic [31:0]        rng_next;
  logic [CHUNK_W-1:0] chunk;
  logic [CNT_W-1:0]   num_words_q;
  logic [CNT_W-1:0]   word_count_inc;
  logic [IN_W-1:0]    fill_data;

  assign rng_next       = rng * LCG_A + LCG_C;
  assign word_count_inc = word_count + CNT_W'(1);

  // Merge the freshly stepped LCG value into the chunk being filled; bits of the
  // top chunk beyond IN_W simply have no destination, which truncates it.
  always_comb begin
    // NOTE: assign a default before the loop so every path drives fill_data and no latch is inferred.
    fill_data = stim_data;
    for (int b = 0; b < IN_W; b++) begin
      if ((b / 32) == int'(chunk)) fill_data[b] = rng_next[b % 32];
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register sees the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rng         <= '0;
      chunk       <= '0;
      num_words_q <= '0;
      stim_data   <= '0;
      stim_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      word_count  <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Abort wins over start and handshake; word_count deliberately keeps its value.
        state      <= S_IDLE;
        chunk      <= '0;
        stim_valid <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              word_count  <= '0;
              num_words_q <= num_words;
              if (num_words != '0) begin
                rng   <= seed;
                chunk <= '0;
                busy  <= 1'b1;
                state <= S_FILL;
              end else begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            end
          end
          S_FILL: begin
            rng       <= rng_next;
            stim_data <= fill_data;
            if (chunk == LAST_CHUNK) begin
              chunk      <= '0;
              stim_valid <= 1'b1;
              state      <= S_PRESENT;
            end else begin
              chunk <= chunk + CHUNK_W'(1);
            end
          end
          S_PRESENT: begin
            if (stim_ready) begin
              stim_valid <= 1'b0;
              word_count <= word_count_inc;
              if (word_count_inc == num_words_q) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                state <= S_FILL;
              end
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
